// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - LC-3 opcode constants and decode FSM state encoding
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT    = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } dec_state_t;

endpackage

// File: rtl/lc3_sext.sv
// rtl/lc3_sext.sv - sign-extends an IN_W-bit field to 16 bits
module lc3_sext #(
  parameter int IN_W = 5
) (
  input  logic [IN_W-1:0] in_val,
  output logic [15:0]     out_val
);

  assign out_val = {{(16-IN_W){in_val[IN_W-1]}}, in_val};

endmodule

// File: rtl/lc3_decode.sv
// rtl/lc3_decode.sv - waits out memory latency, captures IR and decodes its fields
module lc3_decode
  import lc3_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              decode_start,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] pc_in,
  output logic              busy,
  output logic              decode_done,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [3:0]        opcode_out,
  output logic [2:0]        dr_out,
  output logic [2:0]        sr1_out,
  output logic [2:0]        sr2_out,
  output logic              imm_flag_out,
  output logic [15:0]       imm5_sext_out,
  output logic [15:0]       offset6_sext_out,
  output logic [8:0]        offset9_out,
  output logic [15:0]       offset11_sext_out,
  output logic              jsr_long_out,
  output logic [2:0]        br_nzp_out,
  output logic              illegal_op_out
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  dec_state_t       state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             latch_pc, cnt_inc, load_ir, busy_d, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (decode_start) next_state = ST_WAIT;
      ST_WAIT:    if (wait_cnt == CNT_LAST) next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = ST_DONE;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Output strobes; busy/done are computed from next_state so their flops line up with the state.
  always_comb begin
    latch_pc = (state == ST_IDLE) && decode_start;
    cnt_inc  = (state == ST_WAIT);
    load_ir  = (state == ST_CAPTURE);
    busy_d   = (next_state == ST_WAIT) || (next_state == ST_CAPTURE);
    done_d   = (next_state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      pc_out      <= '0;
      ir_out      <= '0;
      busy        <= 1'b0;
      decode_done <= 1'b0;
    end else begin
      busy        <= busy_d;
      decode_done <= done_d;
      if (latch_pc) begin
        pc_out   <= pc_in;
        wait_cnt <= '0;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (load_ir) ir_out <= instr_in;
    end
  end

  assign opcode_out   = ir_out[15:12];
  assign dr_out       = ir_out[11:9];
  assign sr1_out      = ir_out[8:6];
  assign sr2_out      = ir_out[2:0];
  assign imm_flag_out = ir_out[5];
  assign offset9_out  = ir_out[8:0];
  assign jsr_long_out = ir_out[11];
  assign br_nzp_out   = (ir_out[15:12] == OP_BR) ? ir_out[11:9] : 3'b000;
  assign illegal_op_out = (ir_out[15:12] == OP_RES);

  lc3_sext #(.IN_W(5))  u_sext_imm5     (.in_val(ir_out[4:0]),  .out_val(imm5_sext_out));
  lc3_sext #(.IN_W(6))  u_sext_offset6  (.in_val(ir_out[5:0]),  .out_val(offset6_sext_out));
  lc3_sext #(.IN_W(11)) u_sext_offset11 (.in_val(ir_out[10:0]), .out_val(offset11_sext_out));

endmodule

// File: tb/tb_lc3_decode.sv
// tb/tb_lc3_decode.sv - directed bench for lc3_decode at MEM_LATENCY 1 and 3
module tb_lc3_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        decode_start = 1'b0;
  logic        start3 = 1'b0;
  logic [15:0] instr_in = 16'h0000;
  logic [15:0] pc_in = 16'h0000;

  logic        busy, decode_done, imm_flag, jsr_long, illegal;
  logic [15:0] ir, pc, imm5, off6, off11;
  logic [3:0]  opcode;
  logic [2:0]  dr, sr1, sr2, nzp;
  logic [8:0]  off9;

  logic        busy3, done3, imm_flag3, jsr_long3, illegal3;
  logic [15:0] ir3, pc3, imm53, off63, off113;
  logic [3:0]  opcode3;
  logic [2:0]  dr3, sr13, sr23, nzp3;
  logic [8:0]  off93;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  lc3_decode #(.MEM_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .decode_start(decode_start), .instr_in(instr_in), .pc_in(pc_in),
    .busy(busy), .decode_done(decode_done), .ir_out(ir), .pc_out(pc), .opcode_out(opcode),
    .dr_out(dr), .sr1_out(sr1), .sr2_out(sr2), .imm_flag_out(imm_flag), .imm5_sext_out(imm5),
    .offset6_sext_out(off6), .offset9_out(off9), .offset11_sext_out(off11),
    .jsr_long_out(jsr_long), .br_nzp_out(nzp), .illegal_op_out(illegal)
  );

  lc3_decode #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .decode_start(start3), .instr_in(instr_in), .pc_in(pc_in),
    .busy(busy3), .decode_done(done3), .ir_out(ir3), .pc_out(pc3), .opcode_out(opcode3),
    .dr_out(dr3), .sr1_out(sr13), .sr2_out(sr23), .imm_flag_out(imm_flag3), .imm5_sext_out(imm53),
    .offset6_sext_out(off63), .offset9_out(off93), .offset11_sext_out(off113),
    .jsr_long_out(jsr_long3), .br_nzp_out(nzp3), .illegal_op_out(illegal3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle, then returns edges from the sampling edge to decode_done (-1 on timeout).
  // Returns at the negedge where decode_done is first seen.
  task automatic run_decode(input bit sel3, input logic [15:0] pc_v, input logic [15:0] instr_v,
                            output int latency);
    @(negedge clk);
    pc_in = pc_v;
    instr_in = instr_v;
    if (sel3) start3 = 1'b1; else decode_start = 1'b1;
    latency = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start3 = 1'b0;
      decode_start = 1'b0;
      if ((sel3 ? done3 : decode_done) === 1'b1) begin
        latency = k - 1;
        break;
      end
    end
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (decode_done === 1'b1) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    // 1: reset
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", decode_done, 0);
    check("rst_ir", ir, 16'h0000);
    check("rst_nzp", nzp, 0);
    check("rst_pc", pc, 16'h0000);

    // 2: ADD R1,R1,#1
    @(negedge clk);
    pc_in = 16'h3000;
    instr_in = 16'h1261;
    decode_start = 1'b1;
    @(negedge clk);
    decode_start = 1'b0;
    check("busy_in_wait", busy, 1);
    check("no_done_early", decode_done, 0);
    @(negedge clk);
    check("no_done_e1", decode_done, 0);
    @(negedge clk);
    check("done_at_e2", decode_done, 1);
    check("add_opcode", opcode, 4'h1);
    check("add_dr", dr, 3'd1);
    check("add_sr1", sr1, 3'd1);
    check("add_imm_flag", imm_flag, 1);
    check("add_imm5", imm5, 16'h0001);
    check("add_pc", pc, 16'h3000);
    @(negedge clk);
    check("done_one_cycle", decode_done, 0);

    // 3: LD and BRn
    run_decode(1'b0, 16'h3001, 16'h2405, lat);
    check("ld_latency", lat, 2);
    check("ld_opcode", opcode, 4'b0010);
    check("ld_dr", dr, 3'd2);
    check("ld_off9", off9, 9'h005);
    check("ld_nzp", nzp, 3'b000);
    run_decode(1'b0, 16'h3002, 16'h09FF, lat);
    check("br_latency", lat, 2);
    check("br_nzp", nzp, 3'b100);
    check("br_off9", off9, 9'h1FF);

    // 4: sign extension and reserved opcode
    run_decode(1'b0, 16'h3003, 16'h1030, lat);
    check("imm5_neg", imm5, 16'hFFF0);
    check("imm5_off6", off6, 16'hFFF0);
    run_decode(1'b0, 16'h3004, 16'h4FFF, lat);
    check("jsr_long", jsr_long, 1);
    check("jsr_off11", off11, 16'hFFFF);
    run_decode(1'b0, 16'h3005, 16'hD000, lat);
    check("res_latency", lat, 2);
    check("res_illegal", illegal, 1);
    check("res_done", decode_done, 1);

    // 5: extra starts while busy are ignored
    @(negedge clk);
    pc_in = 16'h4000;
    instr_in = 16'h5A2B;
    decode_start = 1'b1;
    @(negedge clk);
    pc_in = 16'h4444;
    @(negedge clk);
    @(negedge clk);
    decode_start = 1'b0;
    check("drop_done", decode_done, 1);
    check("drop_ir", ir, 16'h5A2B);
    check("drop_pc", pc, 16'h4000);
    instr_in = 16'h6666;
    expect_no_done("drop_no_second", 6);
    check("drop_ir_held", ir, 16'h5A2B);

    // start held across DONE: dropped in DONE, accepted one cycle later
    run_decode(1'b0, 16'h4100, 16'h1261, lat);
    instr_in = 16'h7123;
    decode_start = 1'b1;
    @(negedge clk);
    check("b2b_after_done", decode_done, 0);
    @(negedge clk);
    decode_start = 1'b0;
    check("b2b_not_yet", decode_done, 0);
    @(negedge clk);
    check("b2b_not_yet2", decode_done, 0);
    @(negedge clk);
    check("b2b_done", decode_done, 1);
    check("b2b_ir", ir, 16'h7123);

    // 6: reset during WAIT aborts
    @(negedge clk);
    instr_in = 16'h2405;
    decode_start = 1'b1;
    @(negedge clk);
    decode_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ir", ir, 16'h0000);
    check("abort_busy", busy, 0);
    expect_no_done("abort_no_done", 4);
    run_decode(1'b0, 16'h5000, 16'h2405, lat);
    check("after_abort_lat", lat, 2);
    check("after_abort_ir", ir, 16'h2405);

    // MEM_LATENCY = 3
    run_decode(1'b1, 16'h3000, 16'h1261, lat);
    check("l3_latency", lat, 4);
    check("l3_ir", ir3, 16'h1261);
    check("l3_pc", pc3, 16'h3000);
    check("l3_opcode", opcode3, 4'h1);
    check("l3_dr", dr3, 3'd1);
    check("l3_sr1", sr13, 3'd1);
    check("l3_sr2", sr23, 3'd1);
    check("l3_imm_flag", imm_flag3, 1);
    check("l3_imm5", imm53, 16'h0001);
    check("l3_off6", off63, 16'hFFE1);
    check("l3_off9", off93, 9'h061);
    check("l3_off11", off113, 16'h0261);
    check("l3_jsr", jsr_long3, 0);
    check("l3_nzp", nzp3, 3'b000);
    check("l3_illegal", illegal3, 0);
    check("l3_busy", busy3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
